mem_req_ctrl: RTL

- Load/store front-end sitting directly upstream of the stalling single-cycle word memory.
- Accepts byte-addressed byte/half/word requests from the pipeline and holds the memory enable until the memory asserts ready.
- Performs read-modify-write for sub-word stores and sign/zero-extends load data.
- Returns a single-cycle response pulse with data and error status.

---
 rtl/mem_req_ctrl_if.sv | 54 +++++
 rtl/mem_req_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl_if.sv
// Pipeline-side request/response bundle and memory-side access bundle for mem_req_ctrl.
// No latency of its own; these are plain wires grouped for port connection.
// The request side uses valid/ready; the memory side stalls through mem_ready.

interface mem_req_ctrl_req_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    // Pipeline side: issues requests, consumes responses
    modport master (
        output req_valid, req_wr, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Controller side: accepts requests, produces responses
    modport slave (
        input  req_valid, req_wr, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface mem_req_ctrl_mem_if #(
    parameter int ADDR_W = 16
);
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_data_in;
    logic [31:0]       mem_data_out;
    logic              mem_ready;
    logic              mem_err;

    // Controller side: drives the access
    modport master (
        output mem_enable, mem_wr, mem_addr, mem_data_in,
        input  mem_data_out, mem_ready, mem_err
    );

    // Memory side: performs the access
    modport slave (
        input  mem_enable, mem_wr, mem_addr, mem_data_in,
        output mem_data_out, mem_ready, mem_err
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Load/store front-end for a stalling word memory: lane select, RMW for sub-word stores, load extension.
// Latency: accept T, response pulse T+1 (rejected), T+2 (load/word store), T+3 (sub-word store), plus memory stalls.
// Backpressure: req_ready only in IDLE; memory stalls hold the access; responses cannot be stalled. Optional macro STALL_TIMEOUT_EN.

module mem_req_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_req_ctrl_req_if.slave   req,
    mem_req_ctrl_mem_if.master  mem
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              accept;
    logic              misaligned;
    logic              timeout_hit;
    logic [31:0]       rd_shift;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    assign accept = (state_q == S_IDLE) && req.req_valid;

    // Reject misaligned accesses and the reserved size before touching memory
    always_comb begin
        misaligned = 1'b1;
        case (req.req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req.req_addr[0];
            2'b10:   misaligned = |req.req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Extract the addressed lane from the read word and sign/zero-extend it
    always_comb begin
        rd_shift = mem.mem_data_out >> {addr_q[1:0], 3'b000};
        rd_byte  = rd_shift[7:0];
        rd_half  = addr_q[1] ? mem.mem_data_out[31:16] : mem.mem_data_out[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: load_ext = mem.mem_data_out;
        endcase
    end

    // Merge the store lane into the old word; untouched lanes keep their read value
    always_comb begin
        merged = mem.mem_data_out;
        if (size_q == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

`ifdef STALL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_q;

    assign timeout_hit = !mem.mem_ready && (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count stalled cycles within one access phase; any phase change restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if ((state_q == S_READ || state_q == S_WRITE) && !mem.mem_ready
                     && state_d == state_q) begin
            wait_q <= wait_q + CNT_W'(1);
        end else begin
            wait_q <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign timeout_hit    = 1'b0;
`endif

    // Next-state and response/write-word update, defaults first
    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                resp_rdata_d = 32'd0;
                resp_err_d   = 1'b0;
                if (accept) begin
                    if (misaligned) begin
                        state_d    = S_RESP;
                        resp_err_d = 1'b1;
                    end else if (req.req_wr && req.req_size == 2'b10) begin
                        state_d     = S_WRITE;
                        mem_wdata_d = req.req_wdata;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (mem.mem_ready) begin
                    state_d = S_RESP;
                    if (mem.mem_err) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (wr_q) begin
                        state_d     = S_WRITE;
                        mem_wdata_d = merged;
                    end else begin
                        resp_rdata_d = load_ext;
                    end
                end else if (timeout_hit) begin
                    state_d      = S_RESP;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'd0;
                end
            end
            S_WRITE: begin
                if (mem.mem_ready) begin
                    state_d    = S_RESP;
                    resp_err_d = mem.mem_err;
                end else if (timeout_hit) begin
                    state_d    = S_RESP;
                    resp_err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Capture the request on accept; held stable for the whole transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            wr_q    <= req.req_wr;
            addr_q  <= req.req_addr;
            size_q  <= req.req_size;
            uns_q   <= req.req_unsigned;
            wdata_q <= req.req_wdata;
        end
    end

    // Memory controls decode straight from state so reset drops the enable at once
    assign mem.mem_enable  = (state_q == S_READ) || (state_q == S_WRITE);
    assign mem.mem_wr      = (state_q == S_WRITE);
    assign mem.mem_addr    = addr_q[ADDR_W-1:2];
    assign mem.mem_data_in = mem_wdata_q;

    assign req.req_ready   = (state_q == S_IDLE);
    assign req.resp_valid  = (state_q == S_RESP);
    assign req.resp_rdata  = resp_rdata_q;
    assign req.resp_err    = resp_err_q;

endmodule
